cbi980_axil_master: RTL and testbench

- Single-outstanding AXI4-Lite manager (initiator) that converts a simple valid/ready command port into one AXI4-Lite read or write transaction, and returns the result on a response port.
- Drives the CBI980 controller's AXI4-Lite subordinate port from in-fabric logic (test sequencer, boot-time register loader) without a CPU.
- Includes a response watchdog that flags a hung subordinate.

---
 rtl/cbi980_axil_master.sv | 155 +++++++++++++++
 tb/tb_cbi980_axil_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cbi980_axil_master.sv
// Single-outstanding AXI4-Lite manager: one command in, one AXI read or write out, one response back.
// Includes a sticky watchdog that flags a subordinate that stops answering handshakes.
module cbi980_axil_master #(
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [2:0]  PROT    = 3'b000,
  parameter logic [3:0]  CACHE   = 4'b0000
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_we,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_wdata,
  input  logic [3:0]  i_cmd_wstrb,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic [1:0]  o_rsp_resp,
  output logic        o_rsp_we,
  output logic        o_hung,
  output logic [31:0] o_awaddr,
  output logic [2:0]  o_awprot,
  output logic [3:0]  o_awcache,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic [1:0]  i_bresp,
  input  logic        i_bvalid,
  output logic        o_bready,
  output logic [31:0] o_araddr,
  output logic [2:0]  o_arprot,
  output logic [3:0]  o_arcache,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready
);

  typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_RESP} state_t;

  localparam logic [31:0] LP_TO_M1 = TIMEOUT - 32'd1;

  logic [1:0]  r_rst_sync;
  logic        w_rstn;
  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_wait;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_arvalid;
  logic [31:0] r_rsp_rdata;
  logic [1:0]  r_rsp_resp;
  logic [31:0] r_cnt;
  logic        r_hung;

  // Assert asynchronously, release two clock edges after arstn rises.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rstn = r_rst_sync[1];

  assign o_cmd_ready = (r_state == S_IDLE) && w_rstn;
  assign w_accept    = o_cmd_ready && i_cmd_valid;
  assign w_wait      = (r_state == S_WADDR) || (r_state == S_WRESP) ||
                       (r_state == S_RADDR) || (r_state == S_RDATA);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = i_cmd_we ? S_WADDR : S_RADDR;
      S_WADDR: if ((!r_awvalid || i_awready) && (!r_wvalid || i_wready)) w_state_nxt = S_WRESP;
      S_WRESP: if (i_bvalid) w_state_nxt = S_RESP;
      S_RADDR: if (i_arready) w_state_nxt = S_RDATA;
      S_RDATA: if (i_rvalid) w_state_nxt = S_RESP;
      S_RESP:  if (i_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_we        <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_cnt       <= '0;
      r_hung      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr    <= i_cmd_addr;
        r_wdata   <= i_cmd_wdata;
        r_wstrb   <= i_cmd_wstrb;
        r_we      <= i_cmd_we;
        r_awvalid <= i_cmd_we;
        r_wvalid  <= i_cmd_we;
        r_arvalid <= !i_cmd_we;
      end
      // Each valid drops only on its own handshake.
      if (r_awvalid && i_awready) r_awvalid <= 1'b0;
      if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
      if (r_arvalid && i_arready) r_arvalid <= 1'b0;
      if (r_state == S_WRESP && i_bvalid) begin
        r_rsp_rdata <= '0;
        r_rsp_resp  <= i_bresp;
      end
      if (r_state == S_RDATA && i_rvalid) begin
        r_rsp_rdata <= i_rdata;
        r_rsp_resp  <= i_rresp;
      end
      if (w_state_nxt != r_state)        r_cnt <= '0;
      else if (w_wait && r_cnt != '1)    r_cnt <= r_cnt + 32'd1;
      // Flag only; the FSM keeps waiting so the protocol stays legal.
      if (TIMEOUT != 0 && w_wait && r_cnt == LP_TO_M1) r_hung <= 1'b1;
    end
  end

  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_resp  = r_rsp_resp;
  assign o_rsp_we    = r_we;
  assign o_hung      = r_hung;
  assign o_awaddr    = r_addr;
  assign o_awprot    = PROT;
  assign o_awcache   = CACHE;
  assign o_awvalid   = r_awvalid;
  assign o_wdata     = r_wdata;
  assign o_wstrb     = r_wstrb;
  assign o_wvalid    = r_wvalid;
  assign o_bready    = (r_state == S_WRESP);
  assign o_araddr    = r_addr;
  assign o_arprot    = PROT;
  assign o_arcache   = CACHE;
  assign o_arvalid   = r_arvalid;
  assign o_rready    = (r_state == S_RDATA);

endmodule

// File: tb/tb_cbi980_axil_master.sv
// Directed bench for cbi980_axil_master: table of transactions against a scripted subordinate,
// plus hand sequences for reset release and a reset landing mid-read.
module tb_cbi980_axil_master;

  localparam int TO = 8;

  logic        aclk, arstn;
  logic        i_cmd_valid, i_cmd_we, i_rsp_ready;
  logic [31:0] i_cmd_addr, i_cmd_wdata;
  logic [3:0]  i_cmd_wstrb;
  logic        o_cmd_ready, o_rsp_valid, o_rsp_we, o_hung;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic [31:0] o_awaddr, o_wdata, o_araddr;
  logic [2:0]  o_awprot, o_arprot;
  logic [3:0]  o_awcache, o_arcache, o_wstrb;
  logic        o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
  logic        i_awready, i_wready, i_bvalid, i_arready, i_rvalid;
  logic [1:0]  i_bresp, i_rresp;
  logic [31:0] i_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_hung = 0;

  cbi980_axil_master #(.TIMEOUT(TO), .PROT(3'b000), .CACHE(4'b0000)) dut (
    .aclk(aclk), .arstn(arstn),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_resp(o_rsp_resp), .o_rsp_we(o_rsp_we), .o_hung(o_hung),
    .o_awaddr(o_awaddr), .o_awprot(o_awprot), .o_awcache(o_awcache), .o_awvalid(o_awvalid),
    .i_awready(i_awready), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid),
    .i_wready(i_wready), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_araddr(o_araddr), .o_arprot(o_arprot), .o_arcache(o_arcache), .o_arvalid(o_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid),
    .o_rready(o_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          a_dly;   // aw (write) or ar (read) ready delay
    int          w_dly;
    int          r_dly;   // b (write) or r (read) valid delay
    logic [1:0]  sresp;
    logic [31:0] srdata;
    int          rsp_dly;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int c;
    bit a_ok, w_ok, hs_a, hs_w, done;
    chk("cmd_ready_idle", o_cmd_ready, 1);
    i_cmd_valid = 1; i_cmd_we = v.we; i_cmd_addr = v.addr;
    i_cmd_wdata = v.wdata; i_cmd_wstrb = v.wstrb;
    @(posedge aclk); #1;
    i_cmd_valid = 0;
    i_rdata = v.srdata; i_bresp = v.sresp; i_rresp = v.sresp;
    if (v.we) begin
      chk("awvalid_rise", o_awvalid, 1);
      chk("wvalid_rise", o_wvalid, 1);
      chk("arvalid_on_write", o_arvalid, 0);
      a_ok = 0; w_ok = 0; c = 0;
      while (!(a_ok && w_ok) && c < 40) begin
        i_awready = !a_ok && (c >= v.a_dly);
        i_wready  = !w_ok && (c >= v.w_dly);
        if (o_awvalid) chk("awaddr_stable", o_awaddr, v.addr);
        if (o_wvalid) begin
          chk("wdata_stable", o_wdata, v.wdata);
          chk("wstrb_stable", {28'd0, o_wstrb}, {28'd0, v.wstrb});
        end
        chk("bready_in_waddr", o_bready, 0);
        hs_a = o_awvalid && i_awready;
        hs_w = o_wvalid && i_wready;
        @(posedge aclk); #1;
        if (hs_a) a_ok = 1;
        if (hs_w) w_ok = 1;
        c++;
        chk("awvalid_hold", o_awvalid, !a_ok);
        chk("wvalid_hold", o_wvalid, !w_ok);
      end
      i_awready = 0; i_wready = 0;
      if (!(a_ok && w_ok)) chk("aw_w_handshake_bound", 0, 1);
      c = 0; done = 0;
      while (!done && c < 40) begin
        if (c >= TO) exp_hung = 1;
        chk("bready_in_wresp", o_bready, 1);
        chk("hung_wresp", o_hung, exp_hung);
        chk("rsp_valid_early", o_rsp_valid, 0);
        i_bvalid = (c >= v.r_dly);
        done = i_bvalid && o_bready;
        @(posedge aclk); #1;
        c++;
      end
      i_bvalid = 0;
      if (!done) chk("b_handshake_bound", 0, 1);
    end else begin
      chk("arvalid_rise", o_arvalid, 1);
      chk("awvalid_on_read", o_awvalid, 0);
      a_ok = 0; c = 0;
      while (!a_ok && c < 40) begin
        i_arready = (c >= v.a_dly);
        if (o_arvalid) chk("araddr_stable", o_araddr, v.addr);
        chk("rready_in_raddr", o_rready, 0);
        hs_a = o_arvalid && i_arready;
        @(posedge aclk); #1;
        if (hs_a) a_ok = 1;
        c++;
        chk("arvalid_hold", o_arvalid, !a_ok);
      end
      i_arready = 0;
      if (!a_ok) chk("ar_handshake_bound", 0, 1);
      c = 0; done = 0;
      while (!done && c < 40) begin
        if (c >= TO) exp_hung = 1;
        chk("rready_in_rdata", o_rready, 1);
        chk("hung_rdata", o_hung, exp_hung);
        chk("rsp_valid_early", o_rsp_valid, 0);
        i_rvalid = (c >= v.r_dly);
        done = i_rvalid && o_rready;
        @(posedge aclk); #1;
        c++;
      end
      i_rvalid = 0;
      if (!done) chk("r_handshake_bound", 0, 1);
    end
    chk("rsp_valid", o_rsp_valid, 1);
    chk("bready_in_resp", o_bready, 0);
    chk("rready_in_resp", o_rready, 0);
    for (int k = 0; k < v.rsp_dly; k++) begin
      i_cmd_valid = 1; i_cmd_we = 1; i_cmd_addr = 32'hFFFF_FFF0;
      chk("stall_rsp_valid", o_rsp_valid, 1);
      chk("stall_rsp_rdata", o_rsp_rdata, v.exp_rdata);
      chk("stall_cmd_ready", o_cmd_ready, 0);
      @(posedge aclk); #1;
    end
    i_cmd_valid = 0;
    chk("rsp_rdata", o_rsp_rdata, v.exp_rdata);
    chk("rsp_resp", {30'd0, o_rsp_resp}, {30'd0, v.exp_resp});
    chk("rsp_we", o_rsp_we, v.we);
    chk("hung_resp", o_hung, exp_hung);
    i_rsp_ready = 1;
    @(posedge aclk); #1;
    i_rsp_ready = 0;
    chk("rsp_valid_drop", o_rsp_valid, 0);
    chk("cmd_ready_back", o_cmd_ready, 1);
    chk("no_stray_aw", o_awvalid, 0);
    chk("no_stray_ar", o_arvalid, 0);
  endtask

  initial begin
    //          we addr          wdata          strb a  w  r   sresp  srdata         rspd exp_rdata      exp_resp
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2,  2'b00, 32'hFFFF_FFFF, 0, 32'h0,         2'b00};
    vecs[1] = '{1'b1, 32'h20, 32'hCAFEF00D, 4'h3, 3, 0, 0,  2'b10, 32'h0000_0055, 0, 32'h0,         2'b10};
    vecs[2] = '{1'b0, 32'h24, 32'h0,        4'h0, 2, 0, 5,  2'b10, 32'h12345678,  0, 32'h12345678,  2'b10};
    vecs[3] = '{1'b0, 32'h08, 32'h0,        4'h0, 0, 0, 0,  2'b00, 32'hA5A50001,  6, 32'hA5A50001,  2'b00};
    vecs[4] = '{1'b1, 32'h30, 32'h0BADCAFE, 4'hC, 1, 2, 1,  2'b11, 32'h7777_7777, 0, 32'h0,         2'b11};
    vecs[5] = '{1'b1, 32'h40, 32'h11223344, 4'hF, 0, 0, 12, 2'b01, 32'h0,         0, 32'h0,         2'b01};

    i_cmd_valid = 0; i_cmd_we = 0; i_cmd_addr = 0; i_cmd_wdata = 0; i_cmd_wstrb = 0;
    i_rsp_ready = 0; i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
    i_arready = 0; i_rvalid = 0; i_rresp = 0; i_rdata = 0;
    arstn = 1;
    #1 arstn = 0;
    #2;
    chk("rst_cmd_ready", o_cmd_ready, 0);
    chk("rst_awvalid", o_awvalid, 0);
    chk("rst_wvalid", o_wvalid, 0);
    chk("rst_arvalid", o_arvalid, 0);
    chk("rst_bready", o_bready, 0);
    chk("rst_rready", o_rready, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_rdata", o_rsp_rdata, 0);
    chk("rst_hung", o_hung, 0);
    chk("rst_awaddr", o_awaddr, 0);
    @(posedge aclk); @(posedge aclk); #1;
    arstn = 1;
    @(posedge aclk); #1;
    chk("rst_sync_stage1", o_cmd_ready, 0);
    @(posedge aclk); #1;
    chk("rst_sync_release", o_cmd_ready, 1);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);
    chk("hung_sticky", o_hung, 1);

    // Reset landing while the read waits in RDATA.
    i_cmd_valid = 1; i_cmd_we = 0; i_cmd_addr = 32'h50;
    @(posedge aclk); #1;
    i_cmd_valid = 0; i_arready = 1;
    @(posedge aclk); #1;
    i_arready = 0;
    chk("mid_rready", o_rready, 1);
    #2 arstn = 0;
    #1;
    exp_hung = 0;
    chk("async_rready", o_rready, 0);
    chk("async_arvalid", o_arvalid, 0);
    chk("async_hung", o_hung, 0);
    chk("async_cmd_ready", o_cmd_ready, 0);
    @(posedge aclk); @(posedge aclk); #1;
    arstn = 1;
    @(posedge aclk); @(posedge aclk); #1;
    chk("post_rst_cmd_ready", o_cmd_ready, 1);
    chk("post_rst_rready", o_rready, 0);
    run_txn(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
